shift_add_multiplier_ctrl: RTL and testbench

- Sequential unsigned N x N -> 2N multiplier built around one shared N-bit ripple-carry adder (inputs a and b, sum s, carry-out overflow, no carry-in).
- An FSM runs radix-2 shift-and-add: one adder pass per multiplier bit.
- Valid/ready handshakes on both input and output. The block is the controller that sequences the adder datapath.

---
 rtl/shift_add_multiplier_ctrl.sv | 116 +++++++++++
 tb/tb_shift_add_multiplier_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier_ctrl.sv
// rtl/shift_add_multiplier_ctrl.sv - sequential shift-and-add unsigned multiplier controller

// N-bit ripple-carry adder shared by the multiplier datapath
module sam_rca_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         overflow
);

   logic [N:0] w_carry;

   // bit-serial carry chain, no carry-in
   always_comb begin
      w_carry    = '0;
      s          = '0;
      w_carry[0] = 1'b0;
      for (int i = 0; i < N; i++) begin
         s[i]         = a[i] ^ b[i] ^ w_carry[i];
         w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
      end
      overflow = w_carry[N];
   end

endmodule

// radix-2 shift-and-add FSM: one adder pass per multiplier bit
module shift_add_multiplier_ctrl #(
   parameter  int N  = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_md;
   logic [N-1:0]  r_acc;
   logic [N-1:0]  r_mq;
   logic [CW-1:0] r_cnt;

   logic [N-1:0]  w_sum;
   logic          w_ovf;

   // adder result is only consumed in CALC; outside it the inputs may wander freely
   sam_rca_adder #(.N(N)) u_adder (
      .a        (r_acc),
      .b        (r_md),
      .s        (w_sum),
      .overflow (w_ovf)
   );

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign product   = {r_acc, r_mq};

   // operand capture, N shift/add steps, then hold the result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_md    <= '0;
         r_acc   <= '0;
         r_mq    <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_md    <= a;
                  r_mq    <= b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               // carry lands in acc MSB on the shift, so the 2N-bit product never overflows
               if (r_mq[0]) begin
                  {r_acc, r_mq} <= {w_ovf, w_sum, r_mq[N-1:1]};
               end else begin
                  {r_acc, r_mq} <= {1'b0, r_acc, r_mq[N-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // acc/mq are held so product keeps the last result after returning to IDLE
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier_ctrl.sv
// tb/tb_shift_add_multiplier_ctrl.sv - scoreboard testbench for shift_add_multiplier_ctrl

module tb_shift_add_multiplier_ctrl;

   localparam int N = 8;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;
   logic           busy;

   int n_checks;
   int n_fail;
   int hs_count;
   int pushed;
   logic [2*N-1:0] exp_q[$];

   shift_add_multiplier_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: pops the scoreboard on every output handshake
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL spurious_output: got product 0x%0h with no result expected", product);
            end else begin
               check("product", product, exp_q.pop_front());
            end
            hs_count++;
         end
      end
   end

   // present operands until accepted; optionally record the expected product
   task automatic accept(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                         input logic [2*N-1:0] texp, input bit push);
      int guard;
      guard = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("accept_timeout", (guard < 100) ? 32'd1 : 32'd0, 32'd1);
      a        = ta;
      b        = tb_v;
      in_valid = 1'b1;
      if (push) begin
         exp_q.push_back(texp);
         pushed++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // count edges from acceptance until out_valid is seen
   task automatic wait_done(output int lat);
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) break;
      end
   endtask

   logic [N-1:0]   s_a [3];
   logic [N-1:0]   s_b [3];
   logic [2*N-1:0] s_p [3];

   initial begin
      int lat;
      int idx;
      int guard;
      bit stale;

      n_checks = 0; n_fail = 0; hs_count = 0; pushed = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      s_a[0] = 8'h12; s_b[0] = 8'h34; s_p[0] = 16'h03A8;
      s_a[1] = 8'hFF; s_b[1] = 8'h01; s_p[1] = 16'h00FF;
      s_a[2] = 8'h0F; s_b[2] = 8'h0F; s_p[2] = 16'h00E1;

      // reset state
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_product", product, 16'h0000);

      // 0xFF * 0xFF with consumer always ready
      accept(8'hFF, 8'hFF, 16'hFE01, 1'b1);
      wait_done(lat);
      check("lat_ff_ff", lat, N);
      check("done_busy", busy, 1);
      @(posedge clk);
      @(negedge clk);
      check("pulse_out_valid", out_valid, 0);
      check("pulse_in_ready", in_ready, 1);
      check("idle_product_held", product, 16'hFE01);

      // back-pressure: result must stay put while out_ready is low
      out_ready = 1'b0;
      accept(8'h0D, 8'h0B, 16'h008F, 1'b1);
      wait_done(lat);
      check("lat_0d_0b", lat, N);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_product", product, 16'h008F);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_out_valid", out_valid, 0);

      // zero operands and MSB-only operands
      accept(8'h00, 8'hA5, 16'h0000, 1'b1);
      wait_done(lat);
      check("lat_a0", lat, N);
      accept(8'h80, 8'h00, 16'h0000, 1'b1);
      wait_done(lat);
      check("lat_b0", lat, N);
      accept(8'h80, 8'h80, 16'h4000, 1'b1);
      wait_done(lat);
      check("lat_80_80", lat, N);

      // reset during calculation discards the partial result
      accept(8'hFF, 8'hFF, 16'h0000, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_product", product, 16'h0000);
      stale = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      check("midrst_no_stale", stale, 0);
      accept(8'h03, 8'h05, 16'h000F, 1'b1);
      wait_done(lat);
      check("lat_03_05", lat, N);
      @(posedge clk);

      // in_valid held high across a stream with random back-pressure
      idx = 0;
      guard = 0;
      while (idx < 3 && guard < 500) begin
         @(negedge clk);
         guard++;
         out_ready = 1'($urandom_range(0, 1));
         a        = s_a[idx];
         b        = s_b[idx];
         in_valid = 1'b1;
         if (in_ready === 1'b1) begin
            exp_q.push_back(s_p[idx]);
            pushed++;
            idx++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("stream_accepts", idx, 3);
      guard = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && guard < 500) begin
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("drain_timeout", (guard < 500) ? 32'd1 : 32'd0, 32'd1);
      check("handshake_count", hs_count, pushed);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
